// File: rtl/dds_pkg.sv
// dds_pkg: shared constants for the dds channel scheduler and related blocks
//   CFG_*  : config register addresses
//   CTRL_* : bit positions inside the ctrl register
//   DDS_LAT_* : dds input-to-output latency without / with Taylor correction
package dds_pkg;
    localparam logic [1:0] CFG_INC    = 2'd0;
    localparam logic [1:0] CFG_OFFSET = 2'd1;
    localparam logic [1:0] CFG_CTRL   = 2'd2;
    localparam int CTRL_EN        = 0;
    localparam int CTRL_CLR       = 1;
    localparam int DDS_LAT_LUT    = 4;
    localparam int DDS_LAT_TAYLOR = 7;
endpackage

// File: rtl/dds_channel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request strictly after i_ptr
//   i_req [N]  request vector
//   i_ptr [W]  last granted index
//   o_gnt [N]  one-hot grant (zero when no request)
//   o_idx [W]  granted index
//   o_any      at least one request
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);
    logic [W-1:0] w_c;
    assign o_any = |i_req;
    // Scan from farthest to nearest so the nearest requester after the pointer wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_c   = '0;
        for (int i = N; i >= 1; i--) begin
            w_c = W'((int'(i_ptr) + i) % N);
            if (i_req[w_c]) begin
                o_gnt      = '0;
                o_gnt[w_c] = 1'b1;
                o_idx      = w_c;
            end
        end
    end
endmodule

// File: rtl/dds_channel_scheduler.sv
// dds_channel_scheduler: time-multiplexes one dds between NUM_CH NCO channels
//   cfg_*                : per-channel inc / offset / ctrl register writes
//   m_axis_phase_*       : interleaved phase words (tuser = channel) to the dds
//   tag_ch / tag_valid   : channel of the dds sample emerging this cycle
//   active_mask          : per-channel enable bits
module dds_channel_scheduler
    import dds_pkg::*;
#(
    parameter int PHASE_DW    = 16,
    parameter int NUM_CH      = 4,
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int DDS_LATENCY = DDS_LAT_LUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_addr,
    input  logic [PHASE_DW-1:0] cfg_data,
    output logic [PHASE_DW-1:0] m_axis_phase_tdata,
    output logic [CH_W-1:0]     m_axis_phase_tuser,
    output logic                m_axis_phase_tvalid,
    input  logic                m_axis_phase_tready,
    output logic [CH_W-1:0]     tag_ch,
    output logic                tag_valid,
    output logic [NUM_CH-1:0]   active_mask
);
    logic [PHASE_DW-1:0] r_inc [NUM_CH];
    logic [PHASE_DW-1:0] r_off [NUM_CH];
    logic [PHASE_DW-1:0] r_acc [NUM_CH];
    logic [NUM_CH-1:0]   r_en;
    logic [CH_W-1:0]     r_ptr;
    logic [PHASE_DW-1:0] r_tdata;
    logic [CH_W-1:0]     r_tuser;
    logic                r_tvalid;
    logic [DDS_LATENCY-1:0] r_tag_v;
    logic [CH_W-1:0]     r_tag_ch [DDS_LATENCY];
    logic [NUM_CH-1:0]   w_gnt;
    logic [NUM_CH-1:0]   w_sel;
    logic [CH_W-1:0]     w_idx;
    logic                w_any;
    logic                w_free;

    rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
        .i_req (r_en),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_free = !r_tvalid || m_axis_phase_tready;
    // One-hot config target; out-of-range channels shift out and are ignored.
    assign w_sel  = NUM_CH'(cfg_valid) << cfg_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_inc[c] <= '0;
                r_off[c] <= '0;
                r_acc[c] <= '0;
            end
            for (int i = 0; i < DDS_LATENCY; i++) r_tag_ch[i] <= '0;
            r_en     <= '0;
            r_ptr    <= CH_W'(NUM_CH - 1);
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tvalid <= 1'b0;
            r_tag_v  <= '0;
        end else begin
            if (w_free) begin
                r_tvalid <= w_any;
                if (w_any) begin
                    r_tdata <= r_acc[w_idx] + r_off[w_idx];
                    r_tuser <= w_idx;
                    r_ptr   <= w_idx;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_sel[c] && cfg_addr == CFG_INC) r_inc[c] <= cfg_data;
                if (w_sel[c] && cfg_addr == CFG_OFFSET) r_off[c] <= cfg_data;
                if (w_sel[c] && cfg_addr == CFG_CTRL) r_en[c] <= cfg_data[CTRL_EN];
                // A clear landing on the grant cycle overrides that cycle's accumulate.
                if (w_sel[c] && cfg_addr == CFG_CTRL && cfg_data[CTRL_CLR]) r_acc[c] <= '0;
                else if (w_free && w_gnt[c]) r_acc[c] <= r_acc[c] + r_inc[c];
            end
            // Tag line never stalls: the dds has no backpressure.
            r_tag_v[0]  <= r_tvalid && m_axis_phase_tready;
            r_tag_ch[0] <= r_tuser;
            for (int i = 1; i < DDS_LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_ch[i] <= r_tag_ch[i-1];
            end
        end
    end

    assign m_axis_phase_tdata  = r_tdata;
    assign m_axis_phase_tuser  = r_tuser;
    assign m_axis_phase_tvalid = r_tvalid;
    assign tag_valid           = r_tag_v[DDS_LATENCY-1];
    assign tag_ch              = r_tag_ch[DDS_LATENCY-1];
    assign active_mask         = r_en;
endmodule

// File: tb/tb_dds_channel_scheduler.sv
// tb_dds_channel_scheduler: scoreboard bench for dds_channel_scheduler
module tb_dds_channel_scheduler;
    import dds_pkg::*;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int L  = 4;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [1:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          tready = 1'b1;
    logic [DW-1:0] tdata;
    logic [CW-1:0] tuser;
    logic          tvalid;
    logic [CW-1:0] tag_ch;
    logic          tag_valid;
    logic [N-1:0]  active_mask;

    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;
    beat_t sb[$];
    logic [CW:0] tq[$];
    logic  m_acc;
    logic [CW-1:0] m_ch;
    logic [CW:0]   m_e;

    dds_channel_scheduler #(.PHASE_DW(DW), .NUM_CH(N), .DDS_LATENCY(L)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_valid           (cfg_valid),
        .cfg_ch              (cfg_ch),
        .cfg_addr            (cfg_addr),
        .cfg_data            (cfg_data),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tuser  (tuser),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .tag_ch              (tag_ch),
        .tag_valid           (tag_valid),
        .active_mask         (active_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int ch, input logic [1:0] a, input logic [DW-1:0] d);
        cfg_valid = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_addr  = a;
        cfg_data  = d;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d);
        beat_t b;
        b.ch   = CW'(ch);
        b.data = d;
        sb.push_back(b);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        sb.delete();
        reset  = 1'b1;
        cyc(2);
        reset  = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() > 0 && b < 200) begin
            cyc(1);
            b++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        sb.delete();
    endtask

    // Beat scoreboard plus tag delay model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && tvalid) begin
            if (sb.size() == 0) check("unexpected_beat", 32'(tvalid), 32'd0);
            else begin
                check("tdata", 32'(tdata), 32'(sb[0].data));
                check("tuser", 32'(tuser), 32'(sb[0].ch));
            end
        end
        m_acc = tvalid && tready && !reset;
        m_ch  = (mon_en && tvalid && sb.size() > 0) ? sb[0].ch : tuser;
        if (m_acc && mon_en && sb.size() > 0) void'(sb.pop_front());
        if (tq.size() >= L) begin
            m_e = tq.pop_front();
            check("tag_valid", 32'(tag_valid), 32'(m_e[CW]));
            check("tag_ch", 32'(tag_ch), 32'(m_e[CW-1:0]));
        end
        if (reset) begin
            tq.delete();
            repeat (L) tq.push_back('0);
        end else tq.push_back({m_acc, m_ch});
    end

    initial begin
        // reset state
        do_reset();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_tuser", 32'(tuser), 32'd0);
        check("rst_tag_valid", 32'(tag_valid), 32'd0);
        check("rst_tag_ch", 32'(tag_ch), 32'd0);
        check("rst_mask", 32'(active_mask), 32'd0);

        // single channel stream
        cfg(0, CFG_INC, 16'h1000);
        for (int k = 0; k < 8; k++) push(0, DW'(k * 16'h1000));
        mon_en = 1'b1;
        cfg(0, CFG_CTRL, 16'h0001);
        drain();
        check("mask_ch0", 32'(active_mask), 32'h1);

        // two channels interleaved with offset
        do_reset();
        cfg(0, CFG_INC, 16'h0100);
        cfg(2, CFG_INC, 16'h0200);
        cfg(2, CFG_OFFSET, 16'h8000);
        for (int k = 0; k < 4; k++) begin
            push(0, DW'(k * 16'h0100));
            push(2, DW'(16'h8000 + k * 16'h0200));
        end
        mon_en = 1'b1;
        cfg(0, CFG_CTRL, 16'h0001);
        cfg(2, CFG_CTRL, 16'h0001);
        drain();
        check("mask_ch02", 32'(active_mask), 32'h5);

        // accumulator wrap
        do_reset();
        cfg(1, CFG_INC, 16'h4000);
        push(1, 16'h0000); push(1, 16'h4000); push(1, 16'h8000);
        push(1, 16'hC000); push(1, 16'h0000); push(1, 16'h4000);
        mon_en = 1'b1;
        cfg(1, CFG_CTRL, 16'h0001);
        drain();

        // backpressure hold
        do_reset();
        cfg(3, CFG_INC, 16'h0010);
        cfg(3, CFG_OFFSET, 16'h0005);
        for (int k = 0; k < 10; k++) push(3, DW'(16'h0005 + k * 16'h0010));
        mon_en = 1'b1;
        cfg(3, CFG_CTRL, 16'h0001);
        cyc(4);
        tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            check("stall_valid", 32'(tvalid), 32'd1);
        end
        tready = 1'b1;
        drain();

        // clear coinciding with a grant
        do_reset();
        cfg(0, CFG_INC, 16'h1000);
        push(0, 16'h0000); push(0, 16'h1000); push(0, 16'h2000); push(0, 16'h3000);
        push(0, 16'h0000); push(0, 16'h1000); push(0, 16'h2000);
        mon_en = 1'b1;
        cfg(0, CFG_CTRL, 16'h0001);
        cyc(3);
        cfg(0, CFG_CTRL, 16'h0003);
        drain();

        // disable coinciding with a grant
        do_reset();
        cfg(0, CFG_INC, 16'h1000);
        cfg(1, CFG_INC, 16'h0010);
        push(1, 16'h0000); push(0, 16'h0000); push(1, 16'h0010); push(0, 16'h1000);
        push(1, 16'h0020); push(1, 16'h0030); push(1, 16'h0040);
        mon_en = 1'b1;
        cfg(1, CFG_CTRL, 16'h0001);
        cfg(0, CFG_CTRL, 16'h0001);
        cyc(2);
        cfg(0, CFG_CTRL, 16'h0000);
        drain();
        check("mask_ch1", 32'(active_mask), 32'h2);

        // reset mid-stream under backpressure
        do_reset();
        tready = 1'b0;
        cfg(0, CFG_INC, 16'h0700);
        cfg(1, CFG_INC, 16'h0300);
        cfg(0, CFG_CTRL, 16'h0001);
        cfg(1, CFG_CTRL, 16'h0001);
        cyc(2);
        check("pre_rst_valid", 32'(tvalid), 32'd1);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_tvalid", 32'(tvalid), 32'd0);
        check("mid_rst_tag", 32'(tag_valid), 32'd0);
        check("mid_rst_mask", 32'(active_mask), 32'd0);
        check("mid_rst_tdata", 32'(tdata), 32'd0);
        reset  = 1'b0;
        tready = 1'b1;
        cfg(2, CFG_INC, 16'h0055);
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            check("idle_tvalid", 32'(tvalid), 32'd0);
        end
        // inc/offset were cleared, so ch0 now emits a constant zero phase
        push(0, 16'h0000); push(0, 16'h0000); push(0, 16'h0000);
        mon_en = 1'b1;
        cfg(0, CFG_CTRL, 16'h0001);
        drain();

        cyc(L + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dds_channel_scheduler.md
Name: dds_channel_scheduler

Overview:
Time-multiplexes one dds instance between NUM_CH independent NCO channels. Holds a per-channel phase increment, phase offset, enable and phase accumulator. Each cycle it round-robins over the enabled channels and emits one phase word on an AXI-stream master that feeds the dds phase input. A matching channel tag is delayed by DDS_LATENCY so downstream logic can demultiplex the interleaved sin/cos samples.

Parameters:
PHASE_DW, 16, phase/accumulator width; must equal the dds PHASE_DW.
NUM_CH, 4, number of channels, 2..16.
CH_W, $clog2(NUM_CH), channel index width (derived).
DDS_LATENCY, 4, dds input-to-output latency in cycles (4 without Taylor correction, 7 with it).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  config write strobe, single cycle
cfg_ch  in  CH_W  target channel
cfg_addr  in  2  0=phase_inc, 1=phase_offset, 2=ctrl (bit0 enable, bit1 clear accumulator), 3=reserved (ignored)
cfg_data  in  PHASE_DW  write data
m_axis_phase_tdata  out  PHASE_DW  phase word to dds
m_axis_phase_tuser  out  CH_W  channel of current beat
m_axis_phase_tvalid  out  1  beat valid
m_axis_phase_tready  in  1  sink ready (tie to 1 for dds)
tag_ch  out  CH_W  channel of the dds sample emerging this cycle
tag_valid  out  1  aligned with dds m_axis_out_tvalid
active_mask  out  NUM_CH  current per-channel enable bits

Behaviour:
- Reset: all inc/offset/acc registers = 0, all enables = 0, round-robin pointer = NUM_CH-1, m_axis_phase_tdata = 0, tuser = 0, tvalid = 0, tag delay line cleared (tag_valid = 0, tag_ch = 0), active_mask = 0. Reset asserted mid-stream drops any pending beat in the same cycle. No partial state survives reset.
- Config: a write lands in the register on the clock edge where cfg_valid = 1. The ctrl write sets enable = cfg_data[0]. If cfg_data[1] = 1, the channel accumulator is set to 0 on that same edge. Writes with cfg_addr = 3 are ignored.
- Output register "free" = !tvalid || tready.
- Grant: when free and at least one channel is enabled, select the first enabled channel strictly after the pointer, wrapping modulo NUM_CH. Then:
  - tdata <= acc[ch] + offset[ch], mod 2^PHASE_DW;
  - tuser <= ch;
  - tvalid <= 1;
  - acc[ch] <= acc[ch] + inc[ch], wrapping;
  - pointer <= ch.
- Free and no enabled channel: tvalid <= 0 and the pointer holds.
- Not free (valid && !ready): tdata, tuser, tvalid, all accumulators and the pointer hold. This is standard AXIS stability.
- Latency: enable write at edge t → first beat for that channel valid after edge t+1 at the earliest.
- Simultaneous config and grant on the same channel in the same cycle:
  - the emitted beat uses the old inc/offset/acc values;
  - clear wins over accumulate, so acc = 0;
  - a new inc is used from the next grant onward;
  - a disable write does not cancel the beat granted in that cycle.
- Single enabled channel: it is granted every free cycle. With k channels enabled, each is served once per k accepted beats.
- Tag pipeline: {accepted = tvalid && tready, tuser} enters a DDS_LATENCY-deep shift register every cycle with no stall. tag_valid/tag_ch are its output. Because the dds has no backpressure, the tag stays cycle-aligned with dds output valid.
- Arithmetic is unsigned throughout; all overflows wrap silently.

Decomposition:
- Shared package dds_pkg:
  - cfg address constants CFG_INC = 2'd0, CFG_OFFSET = 2'd1, CFG_CTRL = 2'd2;
  - ctrl bit indices CTRL_EN = 0, CTRL_CLR = 1;
  - DDS latency constants DDS_LAT_LUT = 4, DDS_LAT_TAYLOR = 7.
- One sub-module: rr_arbiter (NUM_CH request vector plus last-grant pointer in, one-hot grant and index out, purely combinational), reusable by other schedulers.
- The tag delay line stays inline.

Test Plan:
1. Reset, then write ch0 inc = 0x1000 and enable ch0; tready = 1 → beats of 0x0000, 0x1000, 0x2000, ... every cycle with tuser = 0; tag_valid rises exactly DDS_LATENCY cycles after the first tvalid.
2. Ch0 inc = 0x0100, ch2 inc = 0x0200, offset2 = 0x8000, enable both → tuser alternates 0, 2, 0, 2; ch0 tdata 0x0000, 0x0100, ...; ch2 tdata 0x8000, 0x8200, ...
3. inc = 0x4000 and 6 beats → tdata 0x0000, 0x4000, 0x8000, 0xC000, 0x0000, 0x4000 (accumulator wrap).
4. Deassert tready for 3 cycles mid-stream → tdata and tuser are held constant; no accumulator advances; the sequence resumes with no skipped or duplicated phase.
5. Clear write on ch0 in the same cycle ch0 is granted (acc = 0x3000) → that beat shows 0x3000, the next ch0 beat shows 0x0000; a disable write in the same cycle still lets the granted beat out, then ch0 is skipped.
6. Assert reset while 2 channels are streaming with tready = 0 → next cycle tvalid = 0, tag_valid = 0, active_mask = 0; after release, no beats appear until a new enable write.
